// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, default width
// and the counter-width helper.
package serial_add_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only datapath element of serial_add_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder reused LSB-first over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input that computes a - b instead.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] sum_sh_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction is a + ~b + 1, so only the load values differ.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New bit enters at the MSB; written as shift/or so WIDTH=1 stays legal.
  assign sum_sh_next = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b_load;
          carry_d  = c_load;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_sh_next;
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          sum_d   = sum_sh_next;
          cout_d  = fa_carry;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Working registers are always loaded before use, so they need no reset.
  always_ff @(posedge clk) begin
    a_sh_q   <= a_sh_d;
    b_sh_q   <= b_sh_d;
    sum_sh_q <= sum_sh_d;
    carry_q  <= carry_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-multiplexes one full_adder cell to add two WIDTH-bit operands, LSB first, one bit per clock.
- Owns the operand shift registers, the carry flop and the bit counter; the full_adder instance is its only datapath.
- Uses a valid/ready handshake on both input and output, so it drops into any streaming path that needs area-cheap addition.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; localparam, not overridable.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- cin  input  1  carry-in, sampled on accept.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result; stable while out_valid is high.
- cout  output  1  final carry out.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE and counter clears.
  - sum = 0, cout = 0, out_valid = 0, busy = 0; in_ready = 1 from the first cycle after reset.
  - A reset mid-RUN or mid-DONE aborts the operation silently; no partial result is output.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid && in_ready: load a_sh = a, b_sh = b, carry_q = cin, cnt = 0, sum_sh = 0, then go to RUN.
- RUN, once per cycle:
  - Full_adder inputs are (a_sh[0], b_sh[0], carry_q).
  - sum_sh shifts right with the fa sum inserted at the MSB; a_sh and b_sh shift right; carry_q takes the fa carry; cnt increments.
  - When cnt == WIDTH-1 at the edge, go to DONE; sum takes the final sum_sh and cout takes the final carry.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge (WIDTH=8 gives 8 edges).
- DONE:
  - out_valid = 1; sum and cout are held.
  - On out_valid && out_ready, return to IDLE at that edge. out_valid falls next cycle; sum and cout keep their value until the next result.
- Simultaneous events:
  - in_valid while not in IDLE is ignored, because in_ready = 0.
  - There is no same-cycle DONE-to-accept bypass; a new operand is accepted in the IDLE cycle at the earliest.
  - Peak throughput is one operation per WIDTH+2 cycles.
- out_ready held low keeps the block in DONE indefinitely with outputs stable.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of a + b + cin.
- WIDTH=1: RUN lasts one cycle; the counter compare still holds.
- The illegal state encoding recovers to IDLE.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Extra input sub (1 bit), sampled on accept.
  - If sub = 1, B is loaded inverted and carry_q is loaded with 1, ignoring cin; result is a − b.
  - cout = 1 means no borrow.
- When undefined:
  - No sub port; the block is add-only and its behaviour is identical to the above.

Decomposition:
- Package serial_add_pkg holds:
  - state encodings S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  - default WIDTH constant;
  - function for CNT_W.
- One sub-module: the existing full_adder (ports a, b, c, sum, carry), instantiated once as the bit-slice. There is no other hierarchy.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> sum=0x96, cout=0; out_valid high exactly 8 edges after accept, for 1 cycle.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: a=0x12, b=0x34, out_ready low for 5 cycles after out_valid, and a second in_valid pulse during that time -> sum=0x46 held stable, in_ready=0, second request not taken until IDLE.
- Reset mid-op: assert rst_n=0 for 1 cycle at bit 3 of a=0xAA+0x55 -> next cycle IDLE, out_valid=0, sum=0. Then 0x01+0x02 -> sum=0x03.
- SERIAL_ADD_SUB_EN defined: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
- Back-to-back: in_valid held high with 4 operand pairs -> accepts spaced WIDTH+2=10 cycles apart, all 4 results correct in order.
